ahb_lite_master: RTL and testbench
==================================

// Module: ahb_lite_master
// PURPOSE
//  Single-initiator AHB-Lite master: turns a valid/ready command port into AHB-Lite SINGLE transfers.
//  Sits between the SoC's local command source and the address decoder / slave mux fabric.
//  Consumes the muxed HREADY/HRDATA/HRESP returned by the slave mux.
//  Pipelines address and data phases, so back-to-back commands issue with no bubble.
// PARAMETERS
//  ADDR_W    32       HADDR / cmd_addr width
//  DATA_W    32       HWDATA / HRDATA width
//  HPROT_VAL 4'b0011  constant HPROT driven on every transfer (data, privileged)
// PORTS
//  HCLK        in   1       bus clock
//  HRESETn     in   1       asynchronous active-low reset
//  cmd_valid   in   1       command offered
//  cmd_ready   out  1       command accepted when cmd_valid&&cmd_ready at HCLK edge
//  cmd_write   in   1       1=write, 0=read
//  cmd_addr    in   ADDR_W  byte address
//  cmd_size    in   3       HSIZE encoding (0=byte,1=half,2=word)
//  cmd_wdata   in   DATA_W  write data
//  rsp_valid   out  1       one-cycle pulse per completed transfer, in issue order
//  rsp_rdata   out  DATA_W  read data (0 for writes)
//  rsp_err     out  1       slave returned ERROR
//  HADDR       out  ADDR_W  ; HWRITE out 1 ; HSIZE out 3 ; HTRANS out 2 ; HWDATA out DATA_W
//  HBURST      out  3       constant SINGLE (3'b000); HPROT out 4 = HPROT_VAL; HMASTLOCK out 1 = 0
//  HREADY      in   1       muxed ready from slave mux
//  HRDATA      in   DATA_W  muxed read data
//  HRESP       in   1       muxed response (present only with AHB_LITE_MASTER_HRESP_EN)
// BEHAVIOUR
//  Reset (async): HTRANS=IDLE, HADDR/HWDATA/HSIZE/HWRITE=0, rsp_valid/rsp_err=0, rsp_rdata=0, all phase flags cleared.
//  Reset mid-transfer aborts everything; no response for in-flight commands.
//  cmd_ready = !aphase_valid || HREADY (combinational from HREADY).
//  Accept at edge N: cycle N+1 drives HTRANS=NONSEQ with registered HADDR/HWRITE/HSIZE (address phase).
//  Address phase completes on the first edge with HREADY=1; command moves to data phase; HWDATA registered at that edge.
//  No accept that edge -> HTRANS=IDLE next cycle. Accept at the same edge -> NONSEQ continues back to back.
//  While HREADY=0, HTRANS/HADDR/HWRITE/HSIZE/HWDATA hold exactly; no cancellation, including during ERROR.
//  Data phase completes on the edge with HREADY=1. At that edge rsp_valid<=1, rsp_rdata<=HRDATA (read) or 0 (write).
//  Response pulses the next cycle, so zero-wait latency is accept edge N -> rsp_valid high in cycle N+3.
//  Throughput: one transfer per cycle with zero-wait slaves; one outstanding address phase plus one data phase.
//  Misaligned cmd_addr/cmd_size is not checked; it is a bench assertion.
// CONFIGURATION
//  AHB_LITE_MASTER_HRESP_EN defined:
//    HRESP port exists; rsp_err<=HRESP at data-phase completion.
//    The two-cycle ERROR (HRESP=1,HREADY=0 then HRESP=1,HREADY=1) is treated as a wait plus completion.
//    The following pipelined command is still issued.
//  Undefined: no HRESP port; rsp_err tied 0.
// STRUCTURE
//  Shared package ahb_lite_pkg:
//    HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HBURST_SINGLE=3'b000
//    HSIZE_BYTE/HALF/WORD, HRESP_OKAY=1'b0, HRESP_ERROR=1'b1
//  Single flat module with no sub-module; phase tracking is two valid flags plus a data-phase write flag.
// TESTING
//  1 Read, zero-wait: cmd addr=0x2000_0004 size=2, HRDATA=0xDEADBEEF -> NONSEQ 1 cycle; rsp_valid 1 cycle, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2 Write with 2 wait states: addr=0x4000_0000 wdata=0x1234_5678 -> HWDATA held 3 cycles; addr/ctrl held; rsp_valid once, rsp_rdata=0.
//  3 Back-to-back: 4 reads at 0x0,0x4,0x8,0xC with cmd_valid constant -> NONSEQ 4 consecutive cycles, 4 rsp pulses in order.
//  4 Wait in data phase while next cmd pending: HREADY=0 for 2 cycles -> cmd_ready=0, 2nd HADDR stable, no rsp until HREADY=1.
//  5 (HRESP_EN) ERROR on write to 0xF000_0000 -> rsp_err=1 for that response; next queued read completes with rsp_err=0.
//  6 Assert HRESETn low mid-wait-state -> HTRANS=IDLE immediately, no rsp_valid; new cmd after release runs normally.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// AHB-Lite encodings shared by the master and its bench.
// Transfer, burst, size and response codes.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_lite_master.sv
// Single-initiator AHB-Lite master issuing SINGLE transfers from a valid/ready port.
// Define AHB_LITE_MASTER_HRESP_EN to add the HRESP input and rsp_err reporting.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [1:0]        HTRANS,
  output logic [DATA_W-1:0] HWDATA,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HRDATA,
`ifdef AHB_LITE_MASTER_HRESP_EN
  input  logic              HRESP,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  logic              aphase_valid;
  logic [DATA_W-1:0] awdata;
  logic              dphase_valid;
  logic              dphase_write;
  logic              accept;
  logic              hresp_s;

`ifdef AHB_LITE_MASTER_HRESP_EN
  assign hresp_s = HRESP;
`else
  assign hresp_s = HRESP_OKAY;
`endif

  assign cmd_ready = !aphase_valid || HREADY;
  assign accept    = cmd_valid && cmd_ready;
  assign HTRANS    = aphase_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      aphase_valid <= 1'b0;
      HADDR        <= '0;
      HWRITE       <= 1'b0;
      HSIZE        <= '0;
      awdata       <= '0;
    end else if (accept) begin
      aphase_valid <= 1'b1;
      HADDR        <= cmd_addr;
      HWRITE       <= cmd_write;
      HSIZE        <= cmd_size;
      awdata       <= cmd_wdata;
    end else if (HREADY) begin
      aphase_valid <= 1'b0;
    end
  end

  // HREADY advances both phases together; ERROR's first cycle is just a wait
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dphase_valid <= 1'b0;
      dphase_write <= 1'b0;
      HWDATA       <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      rsp_valid <= HREADY && dphase_valid;
      if (HREADY) begin
        dphase_valid <= aphase_valid;
        dphase_write <= HWRITE;
        if (aphase_valid)
          HWDATA <= awdata;
        if (dphase_valid) begin
          rsp_rdata <= dphase_write ? '0 : HRDATA;
          rsp_err   <= hresp_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master.
// Inputs change and outputs are sampled on the falling edge.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        HWRITE, HMASTLOCK, HREADY;
  logic [2:0]  HSIZE, HBURST;
  logic [1:0]  HTRANS;
  logic [3:0]  HPROT;
  logic        HRESP;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int vecs = 0;
  int errs = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HREADY(HREADY), .HRDATA(HRDATA),
`ifdef AHB_LITE_MASTER_HRESP_EN
    .HRESP(HRESP),
`endif
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always @(posedge HCLK) begin
    if (HRESETn && cmd_valid && cmd_ready)
      assert ((cmd_size == HSIZE_HALF && cmd_addr[0] == 1'b0) ||
              (cmd_size == HSIZE_WORD && cmd_addr[1:0] == 2'b00) ||
              cmd_size == HSIZE_BYTE)
        else $error("misaligned command addr=%h size=%0d", cmd_addr, cmd_size);
  end

  task automatic test_reset();
    HRESETn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
    cmd_size = 0; cmd_wdata = 0;
    HREADY = 1; HRDATA = 0; HRESP = HRESP_OKAY;
    repeat (2) @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_IDLE || HADDR !== 32'h0 || HWDATA !== 32'h0 ||
        HSIZE !== 3'd0 || HWRITE !== 1'b0) begin
      errs++;
      $display("FAIL reset_bus: htrans=%h haddr=%h hwdata=%h hsize=%0d hwrite=%b want all 0",
               HTRANS, HADDR, HWDATA, HSIZE, HWRITE);
    end
    vecs++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0 ||
        cmd_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_rsp: v=%b d=%h e=%b rdy=%b want 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, cmd_ready);
    end
    vecs++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      errs++;
      $display("FAIL consts: hburst=%h hprot=%h lock=%b want 0 3 0",
               HBURST, HPROT, HMASTLOCK);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_read_zero_wait();
    cmd_valid = 1; cmd_write = 0;
    cmd_addr = 32'h2000_0004; cmd_size = HSIZE_WORD;
    @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h2000_0004 ||
        HWRITE !== 1'b0 || HSIZE !== 3'd2) begin
      errs++;
      $display("FAIL rd_aphase: htrans=%h haddr=%h hwrite=%b hsize=%0d want 2 20000004 0 2",
               HTRANS, HADDR, HWRITE, HSIZE);
    end
    cmd_valid = 0;
    HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_IDLE || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rd_dphase: htrans=%h rsp_valid=%b want 0 0", HTRANS, rsp_valid);
    end
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL rd_rsp: v=%b d=%h e=%b want 1 deadbeef 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rd_pulse: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_write_wait();
    cmd_valid = 1; cmd_write = 1;
    cmd_addr = 32'h4000_0000; cmd_size = HSIZE_WORD;
    cmd_wdata = 32'h1234_5678;
    HRDATA = 32'hFFFF_0000;
    @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h4000_0000 || HWRITE !== 1'b1) begin
      errs++;
      $display("FAIL wr_aphase: htrans=%h haddr=%h hwrite=%b want 2 40000000 1",
               HTRANS, HADDR, HWRITE);
    end
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      HREADY = (i == 2);
      vecs++;
      if (HWDATA !== 32'h1234_5678 || rsp_valid !== 1'b0 ||
          HADDR !== 32'h4000_0000 || HWRITE !== 1'b1) begin
        errs++;
        $display("FAIL wr_hold%0d: hwdata=%h rsp_valid=%b haddr=%h hwrite=%b want 12345678 0 40000000 1",
                 i, HWDATA, rsp_valid, HADDR, HWRITE);
      end
    end
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errs++;
      $display("FAIL wr_rsp: v=%b d=%h e=%b want 1 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL wr_pulse: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1; cmd_write = 0;
    cmd_size = HSIZE_WORD; cmd_addr = 32'h0;
    for (int i = 0; i < 7; i++) begin
      @(negedge HCLK);
      if (i < 4) begin
        vecs++;
        if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'(4 * i) || cmd_ready !== 1'b1) begin
          errs++;
          $display("FAIL b2b_addr%0d: htrans=%h haddr=%h rdy=%b want 2 %h 1",
                   i, HTRANS, HADDR, cmd_ready, 4 * i);
        end
      end
      if (i == 4) begin
        vecs++;
        if (HTRANS !== HTRANS_IDLE) begin
          errs++;
          $display("FAIL b2b_idle: htrans=%h want 0", HTRANS);
        end
      end
      if (i >= 2 && i <= 5) begin
        vecs++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== (32'hB000_0000 | 32'(i - 2))) begin
          errs++;
          $display("FAIL b2b_rsp%0d: v=%b d=%h want 1 %h",
                   i - 2, rsp_valid, rsp_rdata, 32'hB000_0000 | 32'(i - 2));
        end
      end
      if (i == 6) begin
        vecs++;
        if (rsp_valid !== 1'b0) begin
          errs++;
          $display("FAIL b2b_end: rsp_valid=%b want 0", rsp_valid);
        end
      end
      if (i >= 1 && i <= 4) HRDATA = 32'hB000_0000 | 32'(i - 1);
      if (i < 3) cmd_addr = 32'(4 * (i + 1));
      else cmd_valid = 0;
    end
  endtask

  task automatic test_data_wait();
    cmd_valid = 1; cmd_write = 0;
    cmd_size = HSIZE_WORD; cmd_addr = 32'h100;
    @(negedge HCLK);
    cmd_addr = 32'h104;
    @(negedge HCLK);
    cmd_valid = 0;
    HREADY = 0; HRDATA = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (cmd_ready !== 1'b0 || HTRANS !== HTRANS_NONSEQ ||
          HADDR !== 32'h104 || rsp_valid !== 1'b0) begin
        errs++;
        $display("FAIL dw_hold%0d: rdy=%b htrans=%h haddr=%h rsp=%b want 0 2 104 0",
                 i, cmd_ready, HTRANS, HADDR, rsp_valid);
      end
      @(negedge HCLK);
    end
    HREADY = 1; HRDATA = 32'h0000_00C0;
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC0) begin
      errs++;
      $display("FAIL dw_rsp0: v=%b d=%h want 1 c0", rsp_valid, rsp_rdata);
    end
    HRDATA = 32'h0000_00C1;
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hC1) begin
      errs++;
      $display("FAIL dw_rsp1: v=%b d=%h want 1 c1", rsp_valid, rsp_rdata);
    end
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL dw_end: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

`ifdef AHB_LITE_MASTER_HRESP_EN
  task automatic test_error();
    cmd_valid = 1; cmd_write = 1; cmd_size = HSIZE_WORD;
    cmd_addr = 32'hF000_0000; cmd_wdata = 32'hAAAA_5555;
    @(negedge HCLK);
    cmd_write = 0; cmd_addr = 32'h10;
    @(negedge HCLK);
    cmd_valid = 0;
    HRESP = HRESP_ERROR; HREADY = 0;
    @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h10 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL err_wait: htrans=%h haddr=%h rsp=%b want 2 10 0",
               HTRANS, HADDR, rsp_valid);
    end
    HREADY = 1;
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errs++;
      $display("FAIL err_rsp: v=%b e=%b d=%h want 1 1 0", rsp_valid, rsp_err, rsp_rdata);
    end
    HRESP = HRESP_OKAY; HRDATA = 32'h55;
    @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h55) begin
      errs++;
      $display("FAIL err_next: v=%b e=%b d=%h want 1 0 55", rsp_valid, rsp_err, rsp_rdata);
    end
    @(negedge HCLK);
  endtask
`endif

  task automatic test_reset_mid();
    cmd_valid = 1; cmd_write = 0; cmd_size = HSIZE_WORD;
    cmd_addr = 32'h3000_0000;
    @(negedge HCLK);
    cmd_valid = 0; HREADY = 0;
    @(negedge HCLK);
    #2 HRESETn = 1'b0;
    #1;
    vecs++;
    if (HTRANS !== HTRANS_IDLE || HADDR !== 32'h0 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rstmid_now: htrans=%h haddr=%h rsp=%b want 0 0 0",
               HTRANS, HADDR, rsp_valid);
    end
    HREADY = 1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      vecs++;
      if (rsp_valid !== 1'b0 || HTRANS !== HTRANS_IDLE) begin
        errs++;
        $display("FAIL rstmid_quiet%0d: rsp=%b htrans=%h want 0 0", i, rsp_valid, HTRANS);
      end
    end
    cmd_valid = 1; cmd_addr = 32'h8;
    @(negedge HCLK);
    vecs++;
    if (HTRANS !== HTRANS_NONSEQ || HADDR !== 32'h8) begin
      errs++;
      $display("FAIL rstmid_new: htrans=%h haddr=%h want 2 8", HTRANS, HADDR);
    end
    cmd_valid = 0; HRDATA = 32'h77;
    repeat (2) @(negedge HCLK);
    vecs++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h77) begin
      errs++;
      $display("FAIL rstmid_rsp: v=%b d=%h want 1 77", rsp_valid, rsp_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_back_to_back();
    test_data_wait();
`ifdef AHB_LITE_MASTER_HRESP_EN
    test_error();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
